// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between the L1 caches, the arbiter and the memory bus.
// master is the arbiter's view; slave is the caches'/memory's view.
interface cache_mem_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic                  i_reqcyc;
  logic [DATA_WIDTH-1:0] i_req;
  logic [TAG_WIDTH-1:0]  i_reqtag;
  logic                  i_reqack;
  logic                  i_respcyc;
  logic [DATA_WIDTH-1:0] i_resp;
  logic [TAG_WIDTH-1:0]  i_resptag;
  logic                  i_respack;

  logic                  d_reqcyc;
  logic [DATA_WIDTH-1:0] d_req;
  logic [TAG_WIDTH-1:0]  d_reqtag;
  logic                  d_reqack;
  logic                  d_respcyc;
  logic [DATA_WIDTH-1:0] d_resp;
  logic [TAG_WIDTH-1:0]  d_resptag;
  logic                  d_respack;
  logic                  d_writeack;

  logic                  bus_reqcyc;
  logic [DATA_WIDTH-1:0] bus_req;
  logic [TAG_WIDTH-1:0]  bus_reqtag;
  logic                  bus_reqack;
  logic                  bus_respcyc;
  logic [DATA_WIDTH-1:0] bus_resp;
  logic [TAG_WIDTH-1:0]  bus_resptag;
  logic                  bus_respack;
  logic                  bus_writeack;

  modport master (
    input  i_reqcyc, i_req, i_reqtag, i_respack,
    output i_reqack, i_respcyc, i_resp, i_resptag,
    input  d_reqcyc, d_req, d_reqtag, d_respack,
    output d_reqack, d_respcyc, d_resp, d_resptag, d_writeack,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  bus_writeack
  );

  modport slave (
    output i_reqcyc, i_req, i_reqtag, i_respack,
    input  i_reqack, i_respcyc, i_resp, i_resptag,
    output d_reqcyc, d_req, d_reqtag, d_respack,
    input  d_reqack, d_respcyc, d_resp, d_resptag, d_writeack,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output bus_writeack
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter giving the I- and D-cache exclusive use
// of the memory bus for one line fill or write-back at a time.
module cache_mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8
) (
  input logic clk,
  input logic reset,
  cache_mem_arbiter_if.master arb
);
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam int RD_BIT = TAG_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_REQ,
    S_READ_RESP,
    S_WRITE_HDR,
    S_WRITE_DATA
  } state_e;

  typedef enum logic [1:0] {
    O_NONE,
    O_I,
    O_D
  } owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  logic is_read_q, is_read_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic own_cyc;
  logic own_respack;
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0] own_tag;
  logic rd_resp, wr_phase;
  logic req_hs, resp_hs;
  logic own_i, own_d;
  logic grant_i, grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= O_NONE;
      last_q    <= O_D;
      is_read_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      is_read_q <= is_read_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    own_cyc     = 1'b0;
    own_req     = '0;
    own_tag     = '0;
    own_respack = 1'b0;
    unique case (owner_q)
      O_I: begin
        own_cyc     = arb.i_reqcyc;
        own_req     = arb.i_req;
        own_tag     = arb.i_reqtag;
        own_respack = arb.i_respack;
      end
      O_D: begin
        own_cyc     = arb.d_reqcyc;
        own_req     = arb.d_req;
        own_tag     = arb.d_reqtag;
        own_respack = arb.d_respack;
      end
      default: ;
    endcase
  end

  assign own_i    = (owner_q == O_I);
  assign own_d    = (owner_q == O_D);
  assign rd_resp  = (state_q == S_READ_RESP);
  assign wr_phase = (state_q == S_WRITE_HDR) ||
                    (state_q == S_WRITE_DATA);

  assign arb.bus_reqcyc  = own_cyc;
  assign arb.bus_req     = own_req;
  assign arb.bus_reqtag  = own_tag;
  assign arb.bus_respack = rd_resp & own_respack;

  assign req_hs  = own_cyc & arb.bus_reqack;
  assign resp_hs = arb.bus_respcyc & arb.bus_respack;

  assign arb.i_reqack = own_i & arb.bus_reqack;
  assign arb.d_reqack = own_d & arb.bus_reqack;

  // Response path is live only for the read owner in its data phase
  assign arb.i_respcyc = rd_resp & own_i & arb.bus_respcyc;
  assign arb.i_resp    = (rd_resp && own_i) ? arb.bus_resp : '0;
  assign arb.i_resptag = (rd_resp && own_i) ? arb.bus_resptag : '0;
  assign arb.d_respcyc = rd_resp & own_d & arb.bus_respcyc;
  assign arb.d_resp    = (rd_resp && own_d) ? arb.bus_resp : '0;
  assign arb.d_resptag = (rd_resp && own_d) ? arb.bus_resptag : '0;

  assign arb.d_writeack = own_d & wr_phase & ~is_read_q &
                          arb.bus_writeack;

  // On a tie the client not granted last time wins
  assign grant_i = arb.i_reqcyc &
                   (~arb.d_reqcyc | (last_q == O_D));
  assign grant_d = arb.d_reqcyc &
                   (~arb.i_reqcyc | (last_q == O_I));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    is_read_d = is_read_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          grant_i: begin
            owner_d   = O_I;
            last_d    = O_I;
            is_read_d = arb.i_reqtag[RD_BIT];
            cnt_d     = '0;
            state_d   = arb.i_reqtag[RD_BIT] ?
                        S_READ_REQ : S_WRITE_HDR;
          end
          grant_d: begin
            owner_d   = O_D;
            last_d    = O_D;
            is_read_d = arb.d_reqtag[RD_BIT];
            cnt_d     = '0;
            state_d   = arb.d_reqtag[RD_BIT] ?
                        S_READ_REQ : S_WRITE_HDR;
          end
          default: ;
        endcase
      end
      S_READ_REQ: begin
        if (req_hs) state_d = S_READ_RESP;
      end
      S_READ_RESP: begin
        if (resp_hs) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
            owner_d = O_NONE;
          end
        end
      end
      S_WRITE_HDR: begin
        if (req_hs) state_d = S_WRITE_DATA;
      end
      S_WRITE_DATA: begin
        if (req_hs) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
            owner_d = O_NONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = O_NONE;
      end
    endcase
  end
endmodule
